// File: rtl/restoring_divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, unsigned or signed (truncating) per operation.
// Latency WIDTH+2 edges from accept to done (1 edge for divide-by-zero); start is ignored while busy or while done is high.
module restoring_divider_seq #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   ONE_EXT   = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] dq_shift;
    logic [WIDTH-1:0] dv_mag;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic             signed_q;
    logic             q_neg;
    logic             r_neg;
    logic             dz_q;

    logic             accept;
    logic             eff_signed;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // The restore branch only happens when shifted < divisor, so shifted[WIDTH]
    // is then zero and the partial remainder fits back in WIDTH bits.
    always_comb begin
        accept       = (state == S_IDLE) && start && !done;
        eff_signed   = signed_mode & SIGNED_EN;
        dividend_abs = (eff_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_abs  = (eff_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        shifted      = {part_rem, dq_shift[WIDTH-1]};
        trial        = shifted + ~{1'b0, dv_mag} + ONE_EXT;
        q_bit        = ~trial[WIDTH];
        q_fix        = q_neg ? -dq_shift : dq_shift;
        r_fix        = r_neg ? -part_rem : part_rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            part_rem    <= '0;
            dq_shift    <= '0;
            dv_mag      <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            signed_q    <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dividend_q  <= dividend;
                        divisor_q   <= divisor;
                        signed_q    <= eff_signed;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                        if (divisor == '0) begin
                            dz_q  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            dz_q     <= 1'b0;
                            dq_shift <= dividend_abs;
                            dv_mag   <= divisor_abs;
                            q_neg    <= eff_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_neg    <= eff_signed & dividend[WIDTH-1];
                            part_rem <= '0;
                            cnt      <= '0;
                            state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    part_rem <= q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    dq_shift <= {dq_shift[WIDTH-2:0], q_bit};
                    if (cnt == LAST_ITER) begin
                        cnt   <= '0;
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    overflow  <= signed_q && (dividend_q == MOST_NEG) && (divisor_q == ALL_ONES);
                    state     <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (dz_q) begin
                        quotient    <= ALL_ONES;
                        remainder   <= dividend_q;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Bench for restoring_divider_seq: three instances (8-bit signed-capable, 16-bit signed-capable, 8-bit unsigned-only)
// checked against an arithmetic reference model on every done pulse, plus directed literal cases.
module tb_restoring_divider_seq;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        st  [3];
    logic        smd [3];
    logic [15:0] dd  [3];
    logic [15:0] dv  [3];

    logic        bz0, bz1, bz2, dn0, dn1, dn2, dz0, dz1, dz2, ov0, ov1, ov2;
    logic [7:0]  q0, r0, q2, r2;
    logic [15:0] q1, r1;

    logic        bz  [3];
    logic        dn  [3];
    logic        dzf [3];
    logic        ovf [3];
    logic [15:0] qo  [3];
    logic [15:0] ro  [3];

    int   total;
    int   bad;
    exp_t expq [$];

    restoring_divider_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .signed_mode(smd[0]),
        .dividend(dd[0][7:0]), .divisor(dv[0][7:0]), .busy(bz0), .done(dn0),
        .quotient(q0), .remainder(r0), .div_by_zero(dz0), .overflow(ov0));

    restoring_divider_seq #(.WIDTH(16), .SIGNED_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .signed_mode(smd[1]),
        .dividend(dd[1]), .divisor(dv[1]), .busy(bz1), .done(dn1),
        .quotient(q1), .remainder(r1), .div_by_zero(dz1), .overflow(ov1));

    restoring_divider_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .signed_mode(smd[2]),
        .dividend(dd[2][7:0]), .divisor(dv[2][7:0]), .busy(bz2), .done(dn2),
        .quotient(q2), .remainder(r2), .div_by_zero(dz2), .overflow(ov2));

    always_comb begin
        bz[0] = bz0;  bz[1] = bz1;  bz[2] = bz2;
        dn[0] = dn0;  dn[1] = dn1;  dn[2] = dn2;
        dzf[0] = dz0; dzf[1] = dz1; dzf[2] = dz2;
        ovf[0] = ov0; ovf[1] = ov1; ovf[2] = ov2;
        qo[0] = {8'h00, q0}; qo[1] = q1; qo[2] = {8'h00, q2};
        ro[0] = {8'h00, r0}; ro[1] = r1; ro[2] = {8'h00, r2};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic int wid(int idx);
        return (idx == 1) ? 16 : 8;
    endfunction

    // Reference: plain integer division on sign-interpreted operands; SV / and %
    // truncate toward zero with the remainder taking the dividend's sign.
    function automatic exp_t model(int idx, bit sm, logic [15:0] a, logic [15:0] b);
        int     w;
        bit     sgn;
        longint mask, sa, sb, q, r;
        exp_t   e;
        w     = wid(idx);
        sgn   = sm && (idx != 2);
        mask  = (longint'(1) << w) - 1;
        e.idx = 2'(idx);
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        sa    = longint'(a) & mask;
        sb    = longint'(b) & mask;
        if (sb == 0) begin
            e.q  = 16'(mask);
            e.r  = 16'(sa);
            e.dz = 1'b1;
        end else begin
            if (sgn) begin
                if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
                if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
            end
            q    = sa / sb;
            r    = sa % sb;
            e.ov = sgn && (sa == -(longint'(1) << (w - 1))) && (sb == -1);
            e.q  = 16'(q & mask);
            e.r  = 16'(r & mask);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (dn[i] === 1'b1) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: instance %0d pulsed done with nothing outstanding", i);
                end else begin
                    e = expq.pop_front();
                    check("done_instance", 32'(i), 32'(e.idx));
                    check("quotient", 32'(qo[i]), 32'(e.q));
                    check("remainder", 32'(ro[i]), 32'(e.r));
                    check("div_by_zero", 32'(dzf[i]), 32'(e.dz));
                    check("overflow", 32'(ovf[i]), 32'(e.ov));
                end
            end
        end
    end

    task automatic do_op(int idx, bit sm, logic [15:0] a, logic [15:0] b, bit hold);
        int   w;
        int   n;
        exp_t e;
        w = wid(idx);
        @(negedge clk);
        st[idx]  = 1'b1;
        smd[idx] = sm;
        dd[idx]  = a;
        dv[idx]  = b;
        @(posedge clk);
        #1;
        if (!hold) st[idx] = 1'b0;
        e = model(idx, sm, a, b);
        expq.push_back(e);
        n = 0;
        while (n < 100) begin
            if (hold) begin
                dd[idx]  = 16'($urandom);
                dv[idx]  = 16'($urandom);
                smd[idx] = 1'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
            if (dn[idx] === 1'b1) break;
            check("busy_while_running", 32'(bz[idx]), 32'd1);
        end
        st[idx] = 1'b0;
        check("latency", 32'(n), e.dz ? 32'd1 : 32'(w + 2));
        check("busy_at_done", 32'(bz[idx]), 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(dn[idx]), 32'd0);
        check("idle_after_done", 32'(bz[idx]), 32'd0);
        check("result_consumed", 32'(expq.size()), 32'd0);
        expq.delete();
    endtask

    task automatic rand_op(int idx);
        logic [15:0] a, b, mask;
        int          sel;
        mask = (wid(idx) == 16) ? 16'hFFFF : 16'h00FF;
        a    = 16'($urandom) & mask;
        b    = 16'($urandom) & mask;
        sel  = $urandom_range(0, 15);
        if (sel == 0)      b = 16'h0000;
        else if (sel == 1) b = mask;
        else if (sel == 2) b = 16'h0001;
        if ($urandom_range(0, 15) == 0) a = mask ^ (mask >> 1);
        do_op(idx, 1'($urandom), a, b, 1'b0);
    endtask

    task automatic check_idle_outputs(int idx, string tag);
        check({tag, "_busy"}, 32'(bz[idx]), 32'd0);
        check({tag, "_done"}, 32'(dn[idx]), 32'd0);
        check({tag, "_quotient"}, 32'(qo[idx]), 32'd0);
        check({tag, "_remainder"}, 32'(ro[idx]), 32'd0);
        check({tag, "_div_by_zero"}, 32'(dzf[idx]), 32'd0);
        check({tag, "_overflow"}, 32'(ovf[idx]), 32'd0);
    endtask

    initial begin
        exp_t m;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0; smd[i] = 1'b0; dd[i] = '0; dv[i] = '0;
        end
        #12;
        for (int i = 0; i < 3; i++) check_idle_outputs(i, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Pin the reference model against hand-computed answers.
        m = model(0, 1'b0, 16'd100, 16'd7);
        check("model_100_7", {m.q, m.r}, {16'h000E, 16'h0002});
        m = model(0, 1'b1, 16'h009C, 16'h0007);
        check("model_m100_7", {m.q, m.r}, {16'h00F2, 16'h00FE});
        m = model(0, 1'b1, 16'h0007, 16'h00FD);
        check("model_7_m3", {m.q, m.r}, {16'h00FE, 16'h0001});
        m = model(0, 1'b1, 16'h0080, 16'h00FF);
        check("model_ovf", {m.q, m.r, 15'd0, m.ov}, {16'h0080, 16'h0000, 16'h0001});
        m = model(2, 1'b1, 16'h0080, 16'h00FF);
        check("model_unsigned_only", {m.q, m.r, 15'd0, m.ov}, {16'h0000, 16'h0080, 16'h0000});

        do_op(0, 1'b0, 16'd100, 16'd7, 1'b0);
        check("lit_100_7", {qo[0], ro[0]}, {16'd14, 16'd2});
        do_op(0, 1'b1, 16'h009C, 16'h0007, 1'b0);
        check("lit_m100_7", {qo[0], ro[0]}, {16'h00F2, 16'h00FE});
        do_op(0, 1'b1, 16'h0007, 16'h00FD, 1'b0);
        check("lit_7_m3", {qo[0], ro[0]}, {16'h00FE, 16'h0001});
        do_op(0, 1'b0, 16'd25, 16'd0, 1'b0);
        check("lit_dz_unsigned", {qo[0], ro[0], 15'd0, dzf[0]}, {16'h00FF, 16'd25, 16'd1});
        do_op(0, 1'b1, 16'd25, 16'd0, 1'b0);
        check("lit_dz_signed", {qo[0], ro[0], 15'd0, dzf[0]}, {16'h00FF, 16'd25, 16'd1});
        do_op(0, 1'b0, 16'd9, 16'd3, 1'b0);
        check("lit_9_3_clears_dz", {qo[0], ro[0], 15'd0, dzf[0]}, {16'd3, 16'd0, 16'd0});
        do_op(0, 1'b1, 16'h0080, 16'h00FF, 1'b0);
        check("lit_ovf", {qo[0], ro[0], 15'd0, ovf[0]}, {16'h0080, 16'd0, 16'd1});
        do_op(0, 1'b0, 16'h0080, 16'h00FF, 1'b0);
        check("lit_ovf_unsigned", {qo[0], ro[0], 15'd0, ovf[0]}, {16'h0000, 16'h0080, 16'd0});
        do_op(0, 1'b0, 16'd200, 16'd13, 1'b1);
        check("lit_held_start", {qo[0], ro[0]}, {16'd15, 16'd5});
        do_op(2, 1'b1, 16'h0080, 16'h00FF, 1'b0);
        check("lit_signed_disabled", {qo[2], ro[2], 15'd0, ovf[2]}, {16'h0000, 16'h0080, 16'd0});
        do_op(2, 1'b1, 16'd200, 16'd13, 1'b0);
        check("lit_signed_disabled_200_13", {qo[2], ro[2]}, {16'd15, 16'd5});
        do_op(1, 1'b1, 16'h8000, 16'hFFFF, 1'b0);
        check("lit_w16_ovf", {qo[1], ro[1], 15'd0, ovf[1]}, {16'h8000, 16'd0, 16'd1});

        // Abort mid-operation with reset; no done may follow and outputs must clear at once.
        @(negedge clk);
        st[0] = 1'b1; smd[0] = 1'b0; dd[0] = 16'd200; dv[0] = 16'd13;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(bz[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs(0, "async_reset");
        repeat (3) begin
            @(posedge clk);
            #1;
            check("no_done_in_reset", 32'(dn[0]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("no_done_after_abort", 32'(dn[0]), 32'd0);
        end
        do_op(0, 1'b0, 16'd255, 16'd1, 1'b0);
        check("lit_255_1", {qo[0], ro[0]}, {16'd255, 16'd0});

        for (int k = 0; k < 1500; k++) rand_op(0);
        for (int k = 0; k < 1000; k++) rand_op(1);
        for (int k = 0; k < 200; k++)  rand_op(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
